// File: rtl/alu_if_defs.sv
// Shared constants for the ALU byte interface: byte width, opcode field positions
// and FSM state encodings.
package alu_if_defs;

    localparam int BYTE_W   = 8;
    localparam int OP_LSB   = 0;
    localparam int FREQ_LSB = 2;
    localparam int RSVD_MSB = 7;
    localparam int RSVD_LSB = 4;

    localparam logic [2:0] ST_RX_A     = 3'd0;
    localparam logic [2:0] ST_RX_B     = 3'd1;
    localparam logic [2:0] ST_RX_OP    = 3'd2;
    localparam logic [2:0] ST_ISSUE    = 3'd3;
    localparam logic [2:0] ST_WAIT_RES = 3'd4;
    localparam logic [2:0] ST_TX       = 3'd5;

    typedef enum logic [2:0] {
        RX_A     = ST_RX_A,
        RX_B     = ST_RX_B,
        RX_OP    = ST_RX_OP,
        ISSUE    = ST_ISSUE,
        WAIT_RES = ST_WAIT_RES,
        TX       = ST_TX
    } state_t;

    // Opcode bytes with any reserved bit set are rejected.
    function automatic logic opcode_reserved_set(input logic [BYTE_W-1:0] op_byte);
        return |op_byte[RSVD_MSB:RSVD_LSB];
    endfunction

endpackage

// File: rtl/byte_serializer.sv
// Parallel-load shift register that emits an N_BITS word as bytes, LSB first,
// over a valid/ready handshake; done pulses with the last accepted byte.
module byte_serializer
    import alu_if_defs::*;
#(
    parameter int N_BITS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [N_BITS-1:0] load_data,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              done
);

    localparam int NB_BYTES = N_BITS / BYTE_W;
    localparam int CNT_W    = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;

    logic [N_BITS-1:0] data_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              valid_reg;
    logic              accept;
    logic              last_byte;

    assign accept    = valid_reg && tx_ready;
    assign last_byte = (count_reg == CNT_W'(NB_BYTES - 1));
    assign done      = accept && last_byte;
    assign tx_data   = data_reg[BYTE_W-1:0];
    assign tx_valid  = valid_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg  <= '0;
            count_reg <= '0;
            valid_reg <= 1'b0;
        end else if (load) begin
            data_reg  <= load_data;
            count_reg <= '0;
            valid_reg <= 1'b1;
        end else if (accept) begin
            data_reg  <= data_reg >> BYTE_W;
            count_reg <= last_byte ? '0 : count_reg + 1'b1;
            valid_reg <= !last_byte;
        end
    end

endmodule

// File: rtl/alu_byte_interface.sv
// Byte-serial front end for the ALU: assembles A, B and an opcode from a byte
// stream, issues one request, and streams the result back out byte by byte.
module alu_byte_interface
    import alu_if_defs::*;
#(
    parameter int N_BITS       = 32,
    parameter int RESP_TIMEOUT = 1024
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_rx_busy,
    output logic [N_BITS-1:0] o_alu_data_a,
    output logic [N_BITS-1:0] o_alu_data_b,
    output logic [1:0]        o_alu_operation,
    output logic [1:0]        o_alu_freq_clock,
    output logic              o_alu_enable,
    output logic              o_alu_valid,
    input  logic [N_BITS-1:0] i_alu_data,
    input  logic              i_alu_valid,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic              o_error
);

    localparam int NB_BYTES = N_BITS / BYTE_W;
    localparam int CNT_W    = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
    localparam int TO_W     = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [TO_W-1:0]   tmo_reg, tmo_next;
    logic [N_BITS-1:0] asm_a_reg, asm_a_next;
    logic [N_BITS-1:0] asm_b_reg, asm_b_next;
    logic [N_BITS-1:0] data_a_reg, data_b_reg;
    logic [1:0]        op_reg, freq_reg;
    logic              wr_a, wr_b, commit, load_res, ser_done;
    logic              last_rx_byte;

    assign last_rx_byte = (cnt_reg == CNT_W'(NB_BYTES - 1));

    // Operands are assembled in shadow registers so a rejected frame leaves
    // the ALU-facing operand outputs untouched.
    for (genvar gi = 0; gi < NB_BYTES; gi++) begin : g_lane
        assign asm_a_next[gi*BYTE_W +: BYTE_W] = (wr_a && cnt_reg == CNT_W'(gi))
            ? i_rx_data : asm_a_reg[gi*BYTE_W +: BYTE_W];
        assign asm_b_next[gi*BYTE_W +: BYTE_W] = (wr_b && cnt_reg == CNT_W'(gi))
            ? i_rx_data : asm_b_reg[gi*BYTE_W +: BYTE_W];
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        tmo_next   = tmo_reg;
        wr_a       = 1'b0;
        wr_b       = 1'b0;
        commit     = 1'b0;
        load_res   = 1'b0;
        o_error    = 1'b0;
        unique case (state_reg)
            RX_A, RX_B: begin
                if (i_rx_valid) begin
                    wr_a = (state_reg == RX_A);
                    wr_b = (state_reg == RX_B);
                    if (last_rx_byte) begin
                        cnt_next   = '0;
                        state_next = (state_reg == RX_A) ? RX_B : RX_OP;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            RX_OP: begin
                if (i_rx_valid) begin
                    if (opcode_reserved_set(i_rx_data)) begin
                        o_error    = 1'b1;
                        state_next = RX_A;
                    end else begin
                        commit     = 1'b1;
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                tmo_next   = '0;
                state_next = WAIT_RES;
            end
            WAIT_RES: begin
                if (i_alu_valid) begin
                    load_res   = 1'b1;
                    state_next = TX;
                end else if (tmo_reg == TO_W'(RESP_TIMEOUT - 1)) begin
                    o_error    = 1'b1;
                    state_next = RX_A;
                end else begin
                    tmo_next = tmo_reg + 1'b1;
                end
            end
            TX: begin
                if (ser_done) state_next = RX_A;
            end
            default: state_next = RX_A;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_reg  <= RX_A;
            cnt_reg    <= '0;
            tmo_reg    <= '0;
            asm_a_reg  <= '0;
            asm_b_reg  <= '0;
            data_a_reg <= '0;
            data_b_reg <= '0;
            op_reg     <= '0;
            freq_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            tmo_reg   <= tmo_next;
            asm_a_reg <= asm_a_next;
            asm_b_reg <= asm_b_next;
            if (commit) begin
                data_a_reg <= asm_a_reg;
                data_b_reg <= asm_b_reg;
                op_reg     <= i_rx_data[OP_LSB +: 2];
                freq_reg   <= i_rx_data[FREQ_LSB +: 2];
            end
        end
    end

    assign o_rx_busy        = (state_reg == ISSUE) || (state_reg == WAIT_RES) || (state_reg == TX);
    assign o_alu_valid      = (state_reg == ISSUE);
    assign o_alu_enable     = (state_reg == ISSUE) || (state_reg == WAIT_RES);
    assign o_alu_data_a     = data_a_reg;
    assign o_alu_data_b     = data_b_reg;
    assign o_alu_operation  = op_reg;
    assign o_alu_freq_clock = freq_reg;

    byte_serializer #(
        .N_BITS(N_BITS)
    ) u_tx_ser (
        .clk      (i_clock),
        .rst_n    (i_reset),
        .load     (load_res),
        .load_data(i_alu_data),
        .tx_data  (o_tx_data),
        .tx_valid (o_tx_valid),
        .tx_ready (i_tx_ready),
        .done     (ser_done)
    );

endmodule
